// File: rtl/aes_inv_key_schedule_if.sv
// rtl/aes_inv_key_schedule_if.sv - round-key stream between key schedule and inverse cipher
interface aes_inv_key_schedule_if;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_index;
    logic [127:0] round_key;
    logic         rk_last;

    modport master (
        output rk_valid,
        output rk_index,
        output round_key,
        output rk_last,
        input  rk_ready
    );

    modport slave (
        input  rk_valid,
        input  rk_index,
        input  round_key,
        input  rk_last,
        output rk_ready
    );
endinterface

// File: rtl/aes_inv_key_schedule.sv
// rtl/aes_inv_key_schedule.sv - AES-128 key expansion to round 10, then reverse stream of round keys 10..0
module aes_s_box (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // Entry 0 sits in the top byte so the table reads in the usual row order.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bit_pos;

    assign bit_pos = {~a, 3'b000};
    assign y       = SBOX_TABLE[bit_pos +: 8];
endmodule

module aes_inv_key_schedule #(
    parameter int NR        = 10,
    parameter bit ZERO_IDLE = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [127:0]                  key_in,
    output logic                          busy,
    aes_inv_key_schedule_if.master        rk
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EMIT   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_EXPAND = 4'(NR - 1);

    state_t       state;
    logic [3:0]   cnt;
    logic [127:0] key_q;
    logic         valid_q;
    logic         busy_q;

    logic [31:0]  w0, w1, w2, w3;
    logic         expanding;
    logic [31:0]  sub_in;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [3:0]   rc_idx;
    logic [31:0]  t_word;
    logic [31:0]  f0, f1, f2, f3;
    logic [127:0] fwd_key;
    logic [127:0] inv_key;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    assign {w0, w1, w2, w3} = key_q;
    assign expanding        = (state == EXPAND);

    // Forward steps substitute w3; reverse steps substitute the recovered v3 = w3^w2.
    assign sub_in   = expanding ? w3 : (w3 ^ w2);
    assign rot_word = {sub_in[23:0], sub_in[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_s_box u_s_box (
            .a (rot_word[8*g +: 8]),
            .y (sub_word[8*g +: 8])
        );
    end

    assign rc_idx = expanding ? (cnt + 4'd1) : cnt;
    assign t_word = sub_word ^ {rcon(rc_idx), 24'h000000};

    assign f0      = w0 ^ t_word;
    assign f1      = w1 ^ f0;
    assign f2      = w2 ^ f1;
    assign f3      = w3 ^ f2;
    assign fwd_key = {f0, f1, f2, f3};

    assign inv_key = {w0 ^ t_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            key_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        key_q  <= key_in;
                        cnt    <= 4'd0;
                        busy_q <= 1'b1;
                        state  <= EXPAND;
                    end
                end
                EXPAND: begin
                    key_q <= fwd_key;
                    cnt   <= cnt + 4'd1;
                    if (cnt == LAST_EXPAND) begin
                        state   <= EMIT;
                        valid_q <= 1'b1;
                    end
                end
                EMIT: begin
                    if (rk.rk_ready) begin
                        if (cnt != 4'd0) begin
                            key_q <= inv_key;
                            cnt   <= cnt - 4'd1;
                        end else begin
                            state   <= IDLE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign rk.rk_valid  = valid_q;
    assign rk.rk_last   = valid_q && (cnt == 4'd0);
    assign rk.round_key = (ZERO_IDLE && !valid_q) ? '0 : key_q;
    assign rk.rk_index  = (ZERO_IDLE && !valid_q) ? 4'd0 : cnt;
endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb/tb_aes_inv_key_schedule.sv - directed bench for the AES-128 inverse key schedule
module tb_aes_inv_key_schedule;
    localparam logic [127:0] KEY_A1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ZERO  = 128'h0;
    localparam logic [127:0] KEY_OTHER = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;

    aes_inv_key_schedule_if rk_if ();

    aes_inv_key_schedule #(
        .NR        (10),
        .ZERO_IDLE (1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .key_in (key_in),
        .busy   (busy),
        .rk     (rk_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
        logic         last;
    } vec_t;

    vec_t a1_tbl[11];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  busy,             1'b0);
        check({tag, "_valid"}, rk_if.rk_valid,   1'b0);
        check({tag, "_last"},  rk_if.rk_last,    1'b0);
        check({tag, "_index"}, rk_if.rk_index,   4'd0);
        check({tag, "_key"},   rk_if.round_key,  128'h0);
    endtask

    task automatic pulse_start(input logic [127:0] k);
        @(negedge clk);
        start  = 1'b1;
        key_in = k;
        @(negedge clk);
        start  = 1'b0;
        key_in = ~k;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (rk_if.rk_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_wait_bound"}, (n < 40), 1'b1);
    endtask

    task automatic receive_all(input bit stall, input bit poke_emit, input bit chk_b2b);
        for (int e = 0; e < 11; e++) begin
            int n;
            wait_valid($sformatf("stream_e%0d", e), n);
            if (chk_b2b && e > 0)
                check($sformatf("b2b_gap_e%0d", e), n, 0);
            check($sformatf("idx_e%0d", e),  rk_if.rk_index,  a1_tbl[e].idx);
            check($sformatf("key_e%0d", e),  rk_if.round_key, a1_tbl[e].key);
            check($sformatf("last_e%0d", e), rk_if.rk_last,   a1_tbl[e].last);
            if (stall && a1_tbl[e].idx == 4'd7) begin
                rk_if.rk_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check($sformatf("hold_valid_s%0d", s), rk_if.rk_valid,  1'b1);
                    check($sformatf("hold_idx_s%0d", s),   rk_if.rk_index,  4'd7);
                    check($sformatf("hold_key_s%0d", s),   rk_if.round_key, a1_tbl[e].key);
                end
                rk_if.rk_ready = 1'b1;
            end
            if (poke_emit && e == 4) begin
                start  = 1'b1;
                key_in = KEY_OTHER;
            end
            @(negedge clk);
            start = 1'b0;
        end
        check_idle("after_stream");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  xfers;
        bit  found;
        bit  done;

        a1_tbl[0]  = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0};
        a1_tbl[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e, 1'b0};
        a1_tbl[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f, 1'b0};
        a1_tbl[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 1'b0};
        a1_tbl[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd, 1'b0};
        a1_tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc, 1'b0};
        a1_tbl[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00, 1'b0};
        a1_tbl[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b, 1'b0};
        a1_tbl[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f, 1'b0};
        a1_tbl[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b0};
        a1_tbl[10] = '{4'd0,  KEY_A1,                                1'b1};

        rst            = 1'b1;
        start          = 1'b0;
        key_in         = '0;
        rk_if.rk_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // FIPS-197 vector, start-to-valid latency and back-to-back stream
        pulse_start(KEY_A1);
        check("t0_busy",  busy,           1'b1);
        check("t0_valid", rk_if.rk_valid, 1'b0);
        wait_valid("latency", n);
        check("latency_cycles", n, 10);
        receive_all(1'b0, 1'b0, 1'b1);

        // backpressure on idx 7
        pulse_start(KEY_A1);
        receive_all(1'b1, 1'b0, 1'b0);

        // start pulses during EXPAND and EMIT are ignored
        pulse_start(KEY_A1);
        @(negedge clk);
        start  = 1'b1;
        key_in = KEY_OTHER;
        @(negedge clk);
        start  = 1'b0;
        receive_all(1'b0, 1'b1, 1'b0);

        // reset mid-EMIT at idx 4
        pulse_start(KEY_A1);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (rk_if.rk_valid === 1'b1 && rk_if.rk_index == 4'd4)
                found = 1'b1;
            else
                @(negedge clk);
        end
        check("reach_idx4", found, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_idle("mid_reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("post_reset");

        // all-zero key; start coincident with final transfer is ignored
        pulse_start(KEY_ZERO);
        wait_valid("zero", n);
        check("zero_idx10", rk_if.rk_index,  4'd10);
        check("zero_key10", rk_if.round_key, ZERO_RK10);
        xfers = 0;
        done  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (rk_if.rk_valid === 1'b1) begin
                xfers++;
                if (rk_if.rk_last === 1'b1) begin
                    check("zero_idx0", rk_if.rk_index,  4'd0);
                    check("zero_key0", rk_if.round_key, 128'h0);
                    start  = 1'b1;
                    key_in = KEY_OTHER;
                    done   = 1'b1;
                end
            end
            @(negedge clk);
            start = 1'b0;
        end
        check("zero_xfers", xfers, 11);
        check_idle("zero_end");
        repeat (3) @(negedge clk);
        check_idle("late_start_ignored");

        // start accepted again once idle
        pulse_start(KEY_A1);
        check("restart_busy", busy, 1'b1);
        wait_valid("restart", n);
        check("restart_idx10", rk_if.rk_index,  4'd10);
        check("restart_key10", rk_if.round_key, a1_tbl[0].key);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
